// File: rtl/dma_dim2_sched.sv
// Shares one 2-D DMA address generator among N requesters using round-robin grants.
// Define DMA_SCHED_FIXED_PRIO_EN to select fixed priority (lowest index wins) instead.
module dma_dim2_sched #(
  parameter int AW  = 11,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*AW-1:0] req_base,
  input  logic [N*4-1:0]  req_dim0_size,
  input  logic [N*4-1:0]  req_dim0_step,
  input  logic [N*4-1:0]  req_dim1_size,
  input  logic [N*4-1:0]  req_dim1_step,
  output logic [AW-1:0]   g_base,
  output logic [3:0]      g_dim0_size,
  output logic [3:0]      g_dim0_step,
  output logic [3:0]      g_dim1_size,
  output logic [3:0]      g_dim1_step,
  output logic            g_start_valid,
  input  logic            g_start_ready,
  input  logic [AW-1:0]   g_addr,
  input  logic            g_first,
  input  logic            g_last,
  input  logic            g_valid,
  output logic            g_ready,
  output logic [AW-1:0]   m_addr,
  output logic [IDW-1:0]  m_id,
  output logic            m_first,
  output logic            m_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            done_valid,
  output logic [IDW-1:0]  done_id
);
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t         state_q;
  logic [AW-1:0]  g_base_q;
  logic [3:0]     g_d0s_q, g_d0t_q, g_d1s_q, g_d1t_q;
  logic           start_q;
  logic [IDW-1:0] m_id_q;
  logic           done_valid_q;
  logic [IDW-1:0] done_id_q;

  logic [AW-1:0]  base_a [N];
  logic [3:0]     d0s_a [N];
  logic [3:0]     d0t_a [N];
  logic [3:0]     d1s_a [N];
  logic [3:0]     d1t_a [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign base_a[gi] = req_base[gi*AW +: AW];
      assign d0s_a[gi]  = req_dim0_size[gi*4 +: 4];
      assign d0t_a[gi]  = req_dim0_step[gi*4 +: 4];
      assign d1s_a[gi]  = req_dim1_size[gi*4 +: 4];
      assign d1t_a[gi]  = req_dim1_step[gi*4 +: 4];
    end
  endgenerate

  logic [IDW-1:0] win_d;
  logic [IDW-1:0] idx_v;
  logic           any_d;
  logic           zero_d;

`ifdef DMA_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_d = '0;
    any_d = 1'b0;
    idx_v = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx_v = IDW'(k);
      if (req_valid[idx_v]) begin
        win_d = idx_v;
        any_d = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q;

  // Scan downward from ptr+N-1 so the candidate closest to ptr is the last (winning) write.
  always_comb begin
    win_d = '0;
    any_d = 1'b0;
    idx_v = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx_v = IDW'((int'(ptr_q) + k) % N);
      if (req_valid[idx_v]) begin
        win_d = idx_v;
        any_d = 1'b1;
      end
    end
  end
`endif

  assign zero_d    = (d0s_a[win_d] == 4'd0) || (d1s_a[win_d] == 4'd0);
  assign req_ready = (state_q == IDLE && !rst && any_d) ? (N'(1) << win_d) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      g_base_q     <= '0;
      g_d0s_q      <= '0;
      g_d0t_q      <= '0;
      g_d1s_q      <= '0;
      g_d1t_q      <= '0;
      start_q      <= 1'b0;
      m_id_q       <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
`ifndef DMA_SCHED_FIXED_PRIO_EN
      ptr_q        <= '0;
`endif
    end else begin
      done_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            g_base_q <= base_a[win_d];
            g_d0s_q  <= d0s_a[win_d];
            g_d0t_q  <= d0t_a[win_d];
            g_d1s_q  <= d1s_a[win_d];
            g_d1t_q  <= d1t_a[win_d];
            m_id_q   <= win_d;
`ifndef DMA_SCHED_FIXED_PRIO_EN
            ptr_q    <= (win_d == IDW'(N-1)) ? '0 : win_d + 1'b1;
`endif
            // Empty jobs never touch the generator; report completion directly.
            if (zero_d) begin
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_id_q    <= win_d;
            end else begin
              state_q <= START;
              start_q <= 1'b1;
            end
          end
        end
        START: begin
          if (g_start_ready) begin
            start_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (g_valid && m_ready && g_last) begin
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_id_q    <= m_id_q;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign g_base        = g_base_q;
  assign g_dim0_size   = g_d0s_q;
  assign g_dim0_step   = g_d0t_q;
  assign g_dim1_size   = g_d1s_q;
  assign g_dim1_step   = g_d1t_q;
  assign g_start_valid = start_q;
  assign m_id          = m_id_q;
  assign done_valid    = done_valid_q;
  assign done_id       = done_id_q;

  assign m_valid = (state_q == RUN) && g_valid;
  assign g_ready = (state_q == RUN) && m_ready;
  assign m_addr  = g_addr;
  assign m_first = g_first;
  assign m_last  = g_last;
endmodule

// File: doc/dma_dim2_sched.md
# dma_dim2_sched

Round-robin scheduler that shares one 2-D DMA address generator among N requesters. Each requester presents a descriptor (base, dim0/dim1 size and step); the scheduler grants one at a time, loads the generator, forwards its address stream tagged with the owner id, and reports completion. It sits between the compute engines' load/store front-ends and the shared `dma_dim2` address generator.

## Interface
- `AW`, 11, address width.
- `N`, 4, number of requesters (2..8).
- `IDW`, 2, requester id width; must equal clog2(N).

Ports. Vectors are packed with requester i at slice i.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N  descriptor valid, one bit per requester.
- `req_ready`  out  N  one-hot descriptor accept.
- `req_base`  in  N*AW  base address.
- `req_dim0_size`, `req_dim0_step`, `req_dim1_size`, `req_dim1_step`  in  N*4  loop sizes and steps.
- `g_base`  out  AW  registered descriptor to generator.
- `g_dim0_size`, `g_dim0_step`, `g_dim1_size`, `g_dim1_step`  out  4  registered descriptor to generator.
- `g_start_valid`  out  1  generator start request.
- `g_start_ready`  in  1  generator start accept.
- `g_addr`  in  AW  generator address beat.
- `g_first`, `g_last`  in  1  generator beat flags; `g_last` marks the final beat of the job.
- `g_valid`  in  1  generator beat valid.
- `g_ready`  out  1  generator beat ready.
- `m_addr`  out  AW  forwarded address.
- `m_id`  out  IDW  owner of the current job.
- `m_first`, `m_last`  out  1  forwarded beat flags.
- `m_valid`  out  1  forwarded beat valid.
- `m_ready`  in  1  downstream beat ready.
- `done_valid`  out  1  one-cycle job-complete pulse.
- `done_id`  out  IDW  id of the completed job.

## Operation
- FSM states: IDLE, START, RUN, DONE.
- **IDLE**
  - If any `req_valid` is high, grant the winner: pulse `req_ready[w]` for exactly one cycle.
  - Register the winner's descriptor into `g_*` and w into `m_id`.
  - If any size field is 0, go to DONE. Otherwise go to START.
- **START**
  - Drive `g_start_valid`=1 and hold it, with `g_*` stable, until `g_start_ready`. Then go to RUN.
- **RUN**
  - Beats pass through combinationally: `m_valid`=`g_valid`, `g_ready`=`m_ready`, and `m_addr`/`m_first`/`m_last` track `g_addr`/`g_first`/`g_last`.
  - On `g_valid & m_ready & g_last`, go to DONE.
- **DONE**
  - Assert `done_valid`=1 with `done_id`=`m_id` for one cycle, then return to IDLE.
- **Round-robin arbitration**
  - Pointer `ptr` starts at 0.
  - The winner is the first requester with `req_valid` set, searching from index `ptr` upward with wrap-around.
  - On each grant, `ptr` becomes (w+1) mod N.
- **Outside RUN:** `m_valid`=0 and `g_ready`=0. Generator beats outside RUN are a protocol error and are ignored.
- **Requester-side rules**
  - `req_valid` may drop before it is granted.
  - A requester may re-request in the cycle after its `done_valid`.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `req_ready`=0, `g_start_valid`=0, `g_ready`=0, `m_valid`=0, `done_valid`=0, `g_*`=0, `m_id`=0, `done_id`=0.
- **Latency**
  - `req_ready` pulse (cycle T) → `g_start_valid` at T+1.
  - Final-beat accept at cycle E → `done_valid` at E+1 → next `req_ready` possible at E+2.
  - Zero-size job: `req_ready` at T, `done_valid` at T+1, no start or beats issued.
- **Simultaneous requests:** resolved by `ptr` only. With N=4, `ptr`=0 and all four valid, the grant order is 0,1,2,3,0.
- **Backpressure:** `m_ready` low stalls the generator with no beat loss or duplication. The RUN→DONE transition waits for the final beat to be accepted.
- **Reset mid-job:** all state returns to reset values the next cycle. No `done_valid` is issued for the aborted job. The generator shares `rst`.

## Configuration
- Macro `DMA_SCHED_FIXED_PRIO_EN`.
- **Defined:** fixed priority. The lowest-index valid requester always wins, and `ptr` is removed.
- **Undefined (default):** round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Single job:** req0, base=0x010, dim0 size=3 step=1, dim1 size=2 step=4 → `g_start_valid` one cycle after `req_ready[0]`; 6 beats forwarded with `m_id`=0; `done_valid`, `done_id`=0 one cycle after the beat with `m_last`.
- **All four requesters valid from reset:** grants in order 0,1,2,3. With the macro defined: 0,0,0 while req0 keeps requesting.
- **Random `m_ready` (50%) during a 4×4 job:** exactly 16 beats delivered with addresses equal to the generator output; `g_ready` always equals `m_ready` in RUN.
- **Zero size (dim0_size=0):** `done_valid` one cycle after grant; `g_start_valid` never asserted.
- **`rst`=1 in the middle of RUN:** next cycle `m_valid`=0, `g_start_valid`=0, state IDLE, no `done_valid`; a new request then starts normally with `ptr`=0.
- **Generator start stall:** `g_start_ready` held low for 5 cycles → `g_start_valid` and `g_*` stay stable throughout; RUN entered on the accept cycle.
